// File: rtl/datapath_sequencer_if.sv
// Handshake and datapath-drive bundle between the sequencer and its environment.
// The err signal exists only when SEQ_TIMEOUT_EN is defined.
interface datapath_sequencer_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 8
);
    logic              start;
    logic              init_valid;
    logic [WIDTH-1:0]  init_data;
    logic              init_ready;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ready;
    logic [WIDTH-1:0]  mem_rdata;
    logic [WIDTH-1:0]  ir_out;
    logic [WIDTH-1:0]  data_out;
    logic              wen;
    logic              rf_select;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] pc;
`ifdef SEQ_TIMEOUT_EN
    logic              err;
`endif

    modport master (
        input  start, init_valid, init_data, mem_ready, mem_rdata,
        output init_ready, mem_req, mem_addr, ir_out, data_out, wen,
               rf_select, busy, done, pc
`ifdef SEQ_TIMEOUT_EN
        , output err
`endif
    );

    modport slave (
        output start, init_valid, init_data, mem_ready, mem_rdata,
        input  init_ready, mem_req, mem_addr, ir_out, data_out, wen,
               rf_select, busy, done, pc
`ifdef SEQ_TIMEOUT_EN
        , input err
`endif
    );
endinterface

// File: rtl/datapath_sequencer.sv
// Drives the RISC datapath: preloads NREGS registers, then fetches and issues instructions.
// Optional fetch timeout with err output is enabled by defining SEQ_TIMEOUT_EN.
module datapath_sequencer #(
    parameter int               WIDTH     = 32,
    parameter int               ADDR_W    = 8,
    parameter int               NREGS     = 32,
    parameter int               PROG_LEN  = 256,
    parameter logic [WIDTH-1:0] HALT_WORD = 32'hFFFFFFFF
`ifdef SEQ_TIMEOUT_EN
    , parameter int             TIMEOUT   = 15
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    datapath_sequencer_if.master  bus
);

    typedef enum logic [2:0] {IDLE, INIT_SET, INIT_WR, FETCH, ISSUE, WB, HALT} state_t;

    // One extra pc bit lets pc reach PROG_LEN without wrapping.
    localparam int              PC_W    = ADDR_W + 1;
    localparam logic [PC_W-1:0] LAST_PC = PC_W'(PROG_LEN);

    state_t          state;
    logic [PC_W-1:0] pcReg;
    logic [PC_W-1:0] nextPc;
    logic [4:0]      regIdx;

`ifdef SEQ_TIMEOUT_EN
    localparam int TC_W = $clog2(TIMEOUT + 1);
    logic [TC_W-1:0] waitCount;
`endif

    function automatic logic [WIDTH-1:0] irForReg(input logic [4:0] idx);
        logic [WIDTH-1:0] word;
        word        = '0;
        word[15:11] = idx;
        return word;
    endfunction

    assign nextPc       = pcReg + PC_W'(1);
    assign bus.pc       = pcReg[ADDR_W-1:0];
    assign bus.mem_addr = pcReg[ADDR_W-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            pcReg          <= '0;
            regIdx         <= '0;
            bus.ir_out     <= '0;
            bus.data_out   <= '0;
            bus.wen        <= 1'b0;
            bus.rf_select  <= 1'b0;
            bus.mem_req    <= 1'b0;
            bus.init_ready <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            waitCount      <= '0;
            bus.err        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, HALT: begin
                    if (bus.start) begin
                        state          <= INIT_SET;
                        pcReg          <= '0;
                        regIdx         <= '0;
                        bus.ir_out     <= irForReg(5'd0);
                        bus.rf_select  <= 1'b1;
                        bus.init_ready <= 1'b1;
                        bus.busy       <= 1'b1;
                        bus.done       <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
                        bus.err        <= 1'b0;
`endif
                    end
                end
                INIT_SET: begin
                    if (bus.init_valid) begin
                        bus.data_out   <= bus.init_data;
                        bus.init_ready <= 1'b0;
                        bus.wen        <= 1'b1;
                        state          <= INIT_WR;
                    end
                end
                INIT_WR: begin
                    bus.wen <= 1'b0;
                    if (regIdx == 5'(NREGS - 1)) begin
                        regIdx        <= '0;
                        bus.rf_select <= 1'b0;
                        bus.mem_req   <= (pcReg != LAST_PC);
`ifdef SEQ_TIMEOUT_EN
                        waitCount     <= '0;
`endif
                        state         <= FETCH;
                    end else begin
                        regIdx         <= regIdx + 5'd1;
                        bus.ir_out     <= irForReg(regIdx + 5'd1);
                        bus.init_ready <= 1'b1;
                        state          <= INIT_SET;
                    end
                end
                // End of program is checked before any request is honoured.
                FETCH: begin
                    if (pcReg == LAST_PC) begin
                        bus.mem_req <= 1'b0;
                        bus.busy    <= 1'b0;
                        bus.done    <= 1'b1;
                        state       <= HALT;
                    end else if (bus.mem_ready) begin
                        bus.mem_req <= 1'b0;
                        if (bus.mem_rdata == HALT_WORD) begin
                            bus.busy <= 1'b0;
                            bus.done <= 1'b1;
                            state    <= HALT;
                        end else begin
                            bus.ir_out <= bus.mem_rdata;
                            state      <= ISSUE;
                        end
`ifdef SEQ_TIMEOUT_EN
                    end else if (waitCount == TC_W'(TIMEOUT - 1)) begin
                        bus.mem_req <= 1'b0;
                        bus.busy    <= 1'b0;
                        bus.done    <= 1'b1;
                        bus.err     <= 1'b1;
                        state       <= HALT;
                    end else begin
                        waitCount <= waitCount + TC_W'(1);
`endif
                    end
                end
                ISSUE: begin
                    bus.wen <= 1'b1;
                    state   <= WB;
                end
                WB: begin
                    bus.wen     <= 1'b0;
                    pcReg       <= nextPc;
                    bus.mem_req <= (nextPc != LAST_PC);
`ifdef SEQ_TIMEOUT_EN
                    waitCount   <= '0;
`endif
                    state       <= FETCH;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
